sram_axi_slave: RTL and testbench
=================================

Name: sram_axi_slave

Overview:
- AXI4 responder between the bus interconnect and one single-port SRAM macro (IM, DM or ROM-style storage). It is the slave-side end of the memory traffic the CPU wrappers initiate.
- Accepts INCR bursts on AR/R and AW/W/B, converts beats into SRAM accesses with byte-lane write enables, and returns OKAY (or SLVERR when the optional feature is enabled).
- Handles one transaction at a time.

Parameters:
- ID_WIDTH, 8, AXI ID width (interconnect-extended).
- DATA_WIDTH, 32, data width; byte lanes = DATA_WIDTH/8.
- MEM_ADDR_WIDTH, 14, SRAM word-address width (16K words).
- BASE_ADDR, 32'h0001_0000, region base; used only under ADDR_CHECK_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/32/4/3/2  write address; AWLEN = beats-1
- AWVALID in 1; AWREADY out 1
- WDATA/WSTRB/WLAST/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data; WREADY out 1
- BID/BRESP/BVALID  out  ID_WIDTH/2/1  write response; BREADY in 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  same widths as AW  read address; ARREADY out 1
- RID/RDATA/RRESP/RLAST/RVALID  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data; RREADY in 1
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low
- BWEB  out  DATA_WIDTH  SRAM bit write enable, active-low
- A  out  MEM_ADDR_WIDTH  SRAM word address
- DI  out  DATA_WIDTH  SRAM write data
- DO  in  DATA_WIDTH  SRAM read data, valid one cycle after CEB=0 with WEB=1

Behaviour:
- States: IDLE, R_FETCH, R_DATA, W_DATA, W_RESP.
- Reset (rst=0, async) forces:
  - state IDLE; RVALID=BVALID=WREADY=0; CEB=1; WEB=1; BWEB all 1.
  - RDATA, RID, BID = 0; RRESP = BRESP = 2'b00; RLAST = 0; beat counter and address register = 0.
- Reset mid-burst aborts the burst with no response.
- IDLE:
  - AWREADY=1. ARREADY = !AWVALID, so a write wins a same-cycle AW/AR tie.
  - AW handshake: latch AWID, word address AWADDR[MEM_ADDR_WIDTH+1:2], AWLEN; clear beat count; go to W_DATA.
  - AR handshake: latch ARID, address and ARLEN the same way; go to R_FETCH.
- R_FETCH: drive CEB=0, WEB=1, A=addr_q; go to R_DATA.
- R_DATA:
  - On entry, capture DO into the RDATA register.
  - RVALID=1; RID = latched ID; RLAST = (beat == len).
  - RDATA, RLAST and RID stay stable while RREADY=0.
  - On handshake: if last, go to IDLE; otherwise beat+1, addr_q+1, go to R_FETCH.
  - Read latency: AR handshake at cycle T gives first RVALID at T+2; each further beat takes 2 cycles minimum.
- W_DATA:
  - WREADY=1.
  - On W handshake, in the same cycle: CEB=0, WEB=0, A=addr_q, DI=WDATA, and BWEB[8i+7:8i] = {8{~WSTRB[i]}}.
  - After the beat, addr_q+1 and beat+1.
  - When beat == len at handshake, go to W_RESP. Termination follows the count only; WLAST is ignored.
  - WSTRB=0 still pulses CEB/WEB but writes no bits.
- W_RESP: BVALID=1, BID = latched ID, BRESP=OKAY; BREADY returns to IDLE.
- Addressing:
  - Address increments wrap modulo 2^MEM_ADDR_WIDTH.
  - AxSIZE is ignored (full-word beats); burst type is treated as INCR.
- Outside the access cycles listed above, CEB=1 and WEB=1.

Optional Feature:
- Macro: SRAM_AXI_ADDR_CHECK_EN.
- When defined, at each AW/AR handshake the block compares AxADDR[31:MEM_ADDR_WIDTH+2] against BASE_ADDR[31:MEM_ADDR_WIDTH+2]. On mismatch:
  - Reads run the full beat count with CEB held 1, RDATA=0 and RRESP=SLVERR (2'b10).
  - Writes accept all beats with CEB held 1 (no SRAM write) and return BRESP=SLVERR.
- When undefined, upper address bits are ignored and responses are always OKAY.

Test Plan:
- Reset with AWVALID=0 -> AWREADY=1, ARREADY=1, RVALID=BVALID=0, CEB=1. Assert rst=0 mid-R_DATA -> RVALID drops immediately.
- Single write to 0x10000004: AWLEN=0, WDATA=32'hDEADBEEF, WSTRB=4'b0101 -> A=1, BWEB=32'hFF00FF00, WEB=0 for one cycle, then BVALID with BID echoed and BRESP=0.
- 4-beat INCR read from word 3 with RREADY held low 3 cycles on beat 2 -> A sequence 3,4,5,6; RDATA stable while stalled; RLAST only on beat 4; first RVALID 2 cycles after AR handshake.
- AWVALID and ARVALID asserted in the same cycle -> AWREADY=1, ARREADY=0; the write completes, then the read is accepted.
- Write burst AWLEN=1 starting at word 16383 -> second beat lands at A=0 (wrap); BVALID after the 2nd beat regardless of WLAST.
- With SRAM_AXI_ADDR_CHECK_EN: read from 0x2000_0000 -> RRESP=2'b10, RDATA=0, CEB never 0. Without the macro -> same read returns SRAM data with OKAY.

Source files
------------

// File: rtl/sram_axi_slave.sv
// ---------------------------------------------------------------------------
// sram_axi_slave
//   AXI4 responder in front of one single-port SRAM macro. It handles one
//   transaction at a time. INCR read bursts run through AR/R and INCR write
//   bursts run through AW/W/B. Each beat becomes one SRAM access with byte-lane
//   write enables.
//
//   Optional build macro: SRAM_AXI_ADDR_CHECK_EN
//     When it is defined, an AXI address whose bits above the SRAM window do
//     not match BASE_ADDR is answered with SLVERR. The SRAM is never enabled
//     for such an access, and read data is returned as zero.
//     When it is undefined, the upper address bits are ignored and every
//     response is OKAY.
//
//   Ports
//     clk, rst               clock, asynchronous active-low reset
//     AW*/AWVALID/AWREADY    write address channel (AWLEN = beats-1)
//     W*/WVALID/WREADY       write data channel (WLAST is not used)
//     BID/BRESP/BVALID/BREADY write response channel
//     AR*/ARVALID/ARREADY    read address channel
//     RID/RDATA/RRESP/RLAST/RVALID/RREADY  read data channel
//     CEB, WEB, BWEB         SRAM chip / write / bit-write enables (active-low)
//     A, DI, DO              SRAM word address, write data, read data
//                            (DO is valid one cycle after a read access)
// ---------------------------------------------------------------------------
module sram_axi_slave #(
   parameter int          ID_WIDTH       = 8,
   parameter int          DATA_WIDTH     = 32,
   parameter int          MEM_ADDR_WIDTH = 14,
   parameter logic [31:0] BASE_ADDR      = 32'h0001_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ID_WIDTH-1:0]       AWID,
   input  logic [31:0]               AWADDR,
   input  logic [3:0]                AWLEN,
   input  logic [2:0]                AWSIZE,
   input  logic [1:0]                AWBURST,
   input  logic                      AWVALID,
   output logic                      AWREADY,
   input  logic [DATA_WIDTH-1:0]     WDATA,
   input  logic [DATA_WIDTH/8-1:0]   WSTRB,
   input  logic                      WLAST,
   input  logic                      WVALID,
   output logic                      WREADY,
   output logic [ID_WIDTH-1:0]       BID,
   output logic [1:0]                BRESP,
   output logic                      BVALID,
   input  logic                      BREADY,
   input  logic [ID_WIDTH-1:0]       ARID,
   input  logic [31:0]               ARADDR,
   input  logic [3:0]                ARLEN,
   input  logic [2:0]                ARSIZE,
   input  logic [1:0]                ARBURST,
   input  logic                      ARVALID,
   output logic                      ARREADY,
   output logic [ID_WIDTH-1:0]       RID,
   output logic [DATA_WIDTH-1:0]     RDATA,
   output logic [1:0]                RRESP,
   output logic                      RLAST,
   output logic                      RVALID,
   input  logic                      RREADY,
   output logic                      CEB,
   output logic                      WEB,
   output logic [DATA_WIDTH-1:0]     BWEB,
   output logic [MEM_ADDR_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0]     DI,
   input  logic [DATA_WIDTH-1:0]     DO
);

   localparam int                        NB       = DATA_WIDTH / 8;
   localparam logic [1:0]                OKAY     = 2'b00;
   localparam logic [1:0]                SLVERR   = 2'b10;
   localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, R_FETCH, R_DATA, W_DATA, W_RESP} state_t;

   state_t                    state;
   logic [ID_WIDTH-1:0]       id_q;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic [3:0]                len_q;
   logic [3:0]                beat_q;
   logic                      err_q;
   logic                      rd_first_q;
   logic [DATA_WIDTH-1:0]     rdata_q;
   logic [DATA_WIDTH-1:0]     rd_word;
   logic                      aw_miss;
   logic                      ar_miss;
   logic                      unused_inputs;

`ifdef SRAM_AXI_ADDR_CHECK_EN
   assign aw_miss = AWADDR[31:MEM_ADDR_WIDTH+2] != BASE_ADDR[31:MEM_ADDR_WIDTH+2];
   assign ar_miss = ARADDR[31:MEM_ADDR_WIDTH+2] != BASE_ADDR[31:MEM_ADDR_WIDTH+2];
`else
   assign aw_miss = 1'b0;
   assign ar_miss = 1'b0;
`endif

   // Size and burst type are fixed by design (full-word INCR). The burst
   // ends on the beat count, so WLAST is not needed.
   assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST, WLAST, AWADDR, ARADDR};

   assign AWREADY = (state == IDLE);
   // A write wins a same-cycle tie between AW and AR.
   assign ARREADY = (state == IDLE) && !AWVALID;
   assign RID     = id_q;
   assign BID     = id_q;

   // DO is only valid in the first R_DATA cycle. Later cycles of a stalled
   // beat replay the copy captured in rdata_q.
   assign rd_word = err_q ? '0 : DO;
   assign RDATA   = rd_first_q ? rd_word : rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         rd_first_q <= 1'b0;
         rdata_q    <= '0;
         RVALID     <= 1'b0;
         RLAST      <= 1'b0;
         RRESP      <= OKAY;
         WREADY     <= 1'b0;
         BVALID     <= 1'b0;
         BRESP      <= OKAY;
      end else begin
         rd_first_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (AWVALID) begin
                  id_q   <= AWID;
                  addr_q <= AWADDR[MEM_ADDR_WIDTH+1:2];
                  len_q  <= AWLEN;
                  beat_q <= '0;
                  err_q  <= aw_miss;
                  WREADY <= 1'b1;
                  state  <= W_DATA;
               end else if (ARVALID) begin
                  id_q   <= ARID;
                  addr_q <= ARADDR[MEM_ADDR_WIDTH+1:2];
                  len_q  <= ARLEN;
                  beat_q <= '0;
                  err_q  <= ar_miss;
                  state  <= R_FETCH;
               end
            end
            R_FETCH: begin
               RVALID     <= 1'b1;
               RLAST      <= (beat_q == len_q);
               RRESP      <= err_q ? SLVERR : OKAY;
               rd_first_q <= 1'b1;
               state      <= R_DATA;
            end
            R_DATA: begin
               if (rd_first_q) rdata_q <= rd_word;
               if (RREADY) begin
                  RVALID <= 1'b0;
                  RLAST  <= 1'b0;
                  if (beat_q == len_q) begin
                     state <= IDLE;
                  end else begin
                     beat_q <= beat_q + 4'd1;
                     addr_q <= addr_q + ADDR_ONE;
                     state  <= R_FETCH;
                  end
               end
            end
            W_DATA: begin
               if (WVALID) begin
                  addr_q <= addr_q + ADDR_ONE;
                  beat_q <= beat_q + 4'd1;
                  if (beat_q == len_q) begin
                     WREADY <= 1'b0;
                     BVALID <= 1'b1;
                     BRESP  <= err_q ? SLVERR : OKAY;
                     state  <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  BVALID <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // SRAM strobes. A write goes out in the same cycle as its W handshake.
   // A rejected (out-of-region) access never enables the macro.
   always_comb begin
      CEB  = 1'b1;
      WEB  = 1'b1;
      BWEB = '1;
      A    = addr_q;
      DI   = WDATA;
      if (state == R_FETCH && !err_q) CEB = 1'b0;
      if (state == W_DATA && WVALID && !err_q) begin
         CEB = 1'b0;
         WEB = 1'b0;
         for (int i = 0; i < NB; i++) BWEB[8*i +: 8] = {8{~WSTRB[i]}};
      end
   end

endmodule

// File: tb/tb_sram_axi_slave.sv
// ---------------------------------------------------------------------------
// tb_sram_axi_slave
//   Directed scoreboard bench for sram_axi_slave. The stimulus process pushes
//   the expected SRAM accesses and AXI responses into queues. A monitor pops
//   and compares them whenever the DUT presents the matching event. Point
//   checks of static outputs go through a queue that the monitor evaluates
//   on the next falling edge. An untouched SRAM word reads as
//   32'hA500_0000 | word_address.
// ---------------------------------------------------------------------------
module tb_sram_axi_slave;

`ifdef SRAM_AXI_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  AWID, ARID, BID, RID;
   logic [31:0] AWADDR, ARADDR;
   logic [3:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CEB, WEB;
   logic [31:0] WDATA, RDATA, BWEB, DI, DO;
   logic [3:0]  WSTRB;
   logic [13:0] A;

   sram_axi_slave dut (
      .clk(clk), .rst(rst),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
   );

   always #5 clk = ~clk;

   // SRAM model: synchronous read, masked synchronous write
   logic [31:0] mem [0:16383];
   bit          written [0:16383];

   function automatic logic [31:0] mem_rd(input logic [13:0] a);
      return written[a] ? mem[a] : (32'hA500_0000 | {18'd0, a});
   endfunction

   always @(posedge clk) begin
      if (!CEB) begin
         if (!WEB) begin
            mem[A]     <= (mem_rd(A) & BWEB) | (DI & ~BWEB);
            written[A] <= 1'b1;
         end else begin
            DO <= mem_rd(A);
         end
      end
   end

   // Scoreboard queues
   typedef struct packed { logic [13:0] a; logic [31:0] bweb; logic [31:0] di; } wexp_t;
   typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; logic [7:0] id; } rexp_t;
   typedef struct packed { logic [7:0] id; logic [1:0] resp; } bexp_t;
   typedef struct { int sel; logic [31:0] exp; string name; } pchk_t;

   wexp_t       exp_w[$];
   rexp_t       exp_r[$];
   bexp_t       exp_b[$];
   logic [13:0] exp_ra[$];
   pchk_t       pq[$];

   localparam int S_AWREADY = 0, S_ARREADY = 1, S_RVALID = 2, S_BVALID = 3, S_CEB = 4,
                  S_WEB = 5, S_BWEB = 6, S_RDATA = 7, S_RLAST = 8, S_WREADY = 9;
   localparam int CH_AW = 0, CH_W = 1, CH_B = 2, CH_AR = 3, CH_R = 4;

   int ncmp  = 0;
   int nfail = 0;
   bit done  = 1'b0;

   function automatic logic [31:0] sig(input int s);
      case (s)
         S_AWREADY: return {31'd0, AWREADY};
         S_ARREADY: return {31'd0, ARREADY};
         S_RVALID:  return {31'd0, RVALID};
         S_BVALID:  return {31'd0, BVALID};
         S_CEB:     return {31'd0, CEB};
         S_WEB:     return {31'd0, WEB};
         S_BWEB:    return BWEB;
         S_RDATA:   return RDATA;
         S_RLAST:   return {31'd0, RLAST};
         default:   return {31'd0, WREADY};
      endcase
   endfunction

   function automatic bit in_region(input logic [31:0] addr);
      return !CHK || (addr[31:16] == 16'h0001);
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic missing(input string name);
      ncmp++;
      nfail++;
      $display("FAIL %s: DUT event with no expected entry (t=%0t)", name, $time);
   endtask

   // Monitor: the only process that compares
   always @(negedge clk) begin
      pchk_t p;
      wexp_t w;
      rexp_t r;
      bexp_t b;
      while (pq.size() > 0) begin
         p = pq.pop_front();
         cmp(p.name, sig(p.sel), p.exp);
      end
      if (rst) begin
         if (!CEB && !WEB) begin
            if (exp_w.size() == 0) missing("sram_write");
            else begin
               w = exp_w.pop_front();
               cmp("write_A", {18'd0, A}, {18'd0, w.a});
               cmp("write_BWEB", BWEB, w.bweb);
               cmp("write_DI", DI, w.di);
            end
         end
         if (!CEB && WEB) begin
            if (exp_ra.size() == 0) missing("sram_read");
            else cmp("read_A", {18'd0, A}, {18'd0, exp_ra.pop_front()});
         end
         if (RVALID && RREADY) begin
            if (exp_r.size() == 0) missing("r_beat");
            else begin
               r = exp_r.pop_front();
               cmp("RDATA", RDATA, r.data);
               cmp("RRESP", {30'd0, RRESP}, {30'd0, r.resp});
               cmp("RLAST", {31'd0, RLAST}, {31'd0, r.last});
               cmp("RID", {24'd0, RID}, {24'd0, r.id});
            end
         end
         if (BVALID && BREADY) begin
            if (exp_b.size() == 0) missing("b_resp");
            else begin
               b = exp_b.pop_front();
               cmp("BID", {24'd0, BID}, {24'd0, b.id});
               cmp("BRESP", {30'd0, BRESP}, {30'd0, b.resp});
            end
         end
      end
      if (done) begin
         cmp("left_w", exp_w.size(), 0);
         cmp("left_r", exp_r.size(), 0);
         cmp("left_b", exp_b.size(), 0);
         cmp("left_ra", exp_ra.size(), 0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
         $finish;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "aborting");
   end

   // Stimulus helpers
   task automatic chk(input int sel, input logic [31:0] exp, input string name);
      pq.push_back('{sel, exp, name});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input int ch);
      bit ok;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         case (ch)
            CH_AW:   ok = AWVALID && AWREADY;
            CH_W:    ok = WVALID && WREADY;
            CH_B:    ok = BVALID && BREADY;
            CH_AR:   ok = ARVALID && ARREADY;
            default: ok = RVALID && RREADY;
         endcase
         if (ok) begin
            tick();
            return;
         end
      end
      $display("FAIL handshake_timeout: channel %0d never completed, required completion", ch);
      $fatal(1, "aborting");
   endtask

   task automatic drain();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         #1;
         if (exp_w.size() == 0 && exp_r.size() == 0 && exp_b.size() == 0 && exp_ra.size() == 0) begin
            tick();
            return;
         end
      end
      $display("FAIL drain_timeout: expected events still pending, required none");
      $fatal(1, "aborting");
   endtask

   task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [3:0] s0, input logic [3:0] s1, input logic wl);
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
      wait_hs(CH_AW);
      AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         WVALID = 1'b1;
         WDATA  = (b == 0) ? d0 : d1;
         WSTRB  = (b == 0) ? s0 : s1;
         WLAST  = (b == int'(len)) ? wl : 1'b0;
         wait_hs(CH_W);
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      wait_hs(CH_B);
   endtask

   task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
      wait_hs(CH_AR);
      ARVALID = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
      RREADY = 1'b1;

      // Reset state
      chk(S_AWREADY, 1, "rst_AWREADY");
      chk(S_ARREADY, 1, "rst_ARREADY");
      chk(S_RVALID, 0, "rst_RVALID");
      chk(S_BVALID, 0, "rst_BVALID");
      chk(S_WREADY, 0, "rst_WREADY");
      chk(S_CEB, 1, "rst_CEB");
      chk(S_WEB, 1, "rst_WEB");
      chk(S_BWEB, 32'hFFFF_FFFF, "rst_BWEB");
      chk(S_RDATA, 0, "rst_RDATA");
      chk(S_RLAST, 0, "rst_RLAST");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk(S_AWREADY, 1, "idle_AWREADY");
      chk(S_ARREADY, 1, "idle_ARREADY");
      tick();

      // Single write, partial strobes: lanes 0 and 2 written
      if (in_region(32'h1000_0004)) exp_w.push_back('{14'd1, 32'hFF00_FF00, 32'hDEAD_BEEF});
      exp_b.push_back('{8'h5A, in_region(32'h1000_0004) ? 2'b00 : 2'b10});
      axi_write(8'h5A, 32'h1000_0004, 4'd0, 32'hDEAD_BEEF, 32'h0, 4'b0101, 4'b0, 1'b1);
      drain();
      exp_ra.push_back(14'd1);
      exp_r.push_back('{in_region(32'h1000_0004) ? 32'hA5AD_00EF : 32'hA500_0001, 2'b00, 1'b1, 8'h5B});
      axi_read(8'h5B, 32'h0001_0004, 4'd0);
      drain();

      // 4-beat read from word 3, beat 2 stalled for 3 cycles
      for (int i = 0; i < 4; i++) begin
         exp_ra.push_back(14'(3 + i));
         exp_r.push_back('{32'hA500_0003 + i, 2'b00, (i == 3), 8'h33});
      end
      axi_read(8'h33, 32'h0001_000C, 4'd3);
      chk(S_RVALID, 0, "rd_lat_T1");
      tick();
      chk(S_RVALID, 1, "rd_lat_T2");
      chk(S_RDATA, 32'hA500_0003, "rd_beat1_data");
      tick();
      RREADY = 1'b0;
      chk(S_RVALID, 0, "rd_refetch");
      tick();
      chk(S_RVALID, 1, "stall1_RVALID");
      chk(S_RDATA, 32'hA500_0004, "stall1_RDATA");
      tick();
      chk(S_RDATA, 32'hA500_0004, "stall2_RDATA");
      chk(S_RLAST, 0, "stall2_RLAST");
      tick();
      chk(S_RDATA, 32'hA500_0004, "stall3_RDATA");
      tick();
      RREADY = 1'b1;
      drain();

      // Same-cycle AW/AR: the write goes first
      exp_w.push_back('{14'd16, 32'h0000_0000, 32'h1234_5678});
      exp_b.push_back('{8'h11, 2'b00});
      exp_ra.push_back(14'd17);
      exp_r.push_back('{32'hA500_0011, 2'b00, 1'b1, 8'h22});
      AWID = 8'h11; AWADDR = 32'h0001_0040; AWLEN = 4'd0; AWVALID = 1'b1;
      ARID = 8'h22; ARADDR = 32'h0001_0044; ARLEN = 4'd0; ARVALID = 1'b1;
      chk(S_AWREADY, 1, "tie_AWREADY");
      chk(S_ARREADY, 0, "tie_ARREADY");
      wait_hs(CH_AW);
      AWVALID = 1'b0;
      chk(S_ARREADY, 0, "wdata_ARREADY");
      WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF; WLAST = 1'b1;
      wait_hs(CH_W);
      WVALID = 1'b0; WLAST = 1'b0;
      wait_hs(CH_B);
      wait_hs(CH_AR);
      ARVALID = 1'b0;
      drain();

      // Two-beat write from the top word wraps to word 0; WLAST never driven
      exp_w.push_back('{14'd16383, 32'h0000_0000, 32'hCAFE_0001});
      exp_w.push_back('{14'd0, 32'hFFFF_0000, 32'hCAFE_0002});
      exp_b.push_back('{8'h44, 2'b00});
      axi_write(8'h44, 32'h0001_FFFC, 4'd1, 32'hCAFE_0001, 32'hCAFE_0002, 4'hF, 4'b0011, 1'b0);
      drain();
      exp_ra.push_back(14'd16383);
      exp_ra.push_back(14'd0);
      exp_r.push_back('{32'hCAFE_0001, 2'b00, 1'b0, 8'h55});
      exp_r.push_back('{32'hA500_0002, 2'b00, 1'b1, 8'h55});
      axi_read(8'h55, 32'h0001_FFFC, 4'd1);
      drain();

      // Zero strobe still strobes the macro but changes nothing
      exp_w.push_back('{14'd20, 32'hFFFF_FFFF, 32'h0BAD_F00D});
      exp_b.push_back('{8'h99, 2'b00});
      axi_write(8'h99, 32'h0001_0050, 4'd0, 32'h0BAD_F00D, 32'h0, 4'h0, 4'h0, 1'b1);
      drain();
      exp_ra.push_back(14'd20);
      exp_r.push_back('{32'hA500_0014, 2'b00, 1'b1, 8'h9A});
      axi_read(8'h9A, 32'h0001_0050, 4'd0);
      drain();

      // Out-of-region read
      if (in_region(32'h2000_0020)) begin
         exp_ra.push_back(14'd8);
         exp_r.push_back('{32'hA500_0008, 2'b00, 1'b1, 8'h66});
      end else begin
         exp_r.push_back('{32'h0000_0000, 2'b10, 1'b1, 8'h66});
      end
      axi_read(8'h66, 32'h2000_0020, 4'd0);
      drain();

      // Reset in the middle of R_DATA drops RVALID at once
      RREADY = 1'b0;
      exp_ra.push_back(14'd4);
      axi_read(8'h77, 32'h0001_0010, 4'd1);
      tick();
      #2 rst = 1'b0;
      chk(S_RVALID, 0, "midrst_RVALID");
      chk(S_RDATA, 0, "midrst_RDATA");
      chk(S_CEB, 1, "midrst_CEB");
      tick();
      tick();
      rst = 1'b1;
      RREADY = 1'b1;
      chk(S_AWREADY, 1, "postrst_AWREADY");
      chk(S_RVALID, 0, "postrst_RVALID");
      tick();
      exp_ra.push_back(14'd5);
      exp_r.push_back('{32'hA500_0005, 2'b00, 1'b1, 8'h78});
      axi_read(8'h78, 32'h0001_0014, 4'd0);
      drain();

      done = 1'b1;
   end

endmodule
